// File: rtl/bitwise_arbiter.sv
// Shares one WIDTH-bit bitwise logic unit (NOT/AND/OR/XOR) between two requesters.
// A round-robin arbiter accepts one request at a time and holds the tagged result until the consumer accepts it.
module bitwise_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,

    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready,

    output logic             busy,
    output logic             dbg_state_o
);

    // Handshakes: a transfer happens on any rising edge where valid & ready are both high.
    // Requesters may raise or drop valid freely; ready never depends on ready of the other side.

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             grant0, grant1;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] alu_result;

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Round robin: on a tie the requester that was not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_grant_q);
            grant1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    assign accept = grant0 || grant1;

    always_comb begin
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        if (grant1) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end
    end

    assign alu_result = logic_op(sel_op, sel_a, sel_b);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = RESP;
                    last_grant_d = grant1;
                    rsp_id_d     = grant1;
                    rsp_data_d   = alu_result;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready  = grant0;
        req1_ready  = grant1;
        rsp_valid   = (state_q == RESP);
        busy        = (state_q == RESP);
        rsp_id      = rsp_id_q;
        rsp_data    = rsp_data_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_bitwise_arbiter.sv
// Self-checking bench for bitwise_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_bitwise_arbiter;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic [1:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             rsp_valid, rsp_id, rsp_ready, busy, dbg_state_o;
    logic [WIDTH-1:0] rsp_data;

    int pass_cnt;
    int total_cnt;

    bitwise_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for the logic unit, straight from the operation table.
    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return ~a;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp_ready  = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++;
            if ({rsp_valid, rsp_id, rsp_data, busy, req0_ready, req1_ready} !== '0) begin
                $display("FAIL reset_idle cyc=%0d: valid=%b id=%b data=%h busy=%b rdy0=%b rdy1=%b, required all 0",
                         i, rsp_valid, rsp_id, rsp_data, busy, req0_ready, req1_ready);
            end else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_single_ops();
        logic [1:0]       ops [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [WIDTH-1:0] as  [5] = '{16'h0000, 16'hAAAA, 16'h1234, 16'h3C00, 16'hFFFF};
        logic [WIDTH-1:0] bs  [5] = '{16'h0000, 16'h0000, 16'h00FF, 16'h00C3, 16'h1234};
        logic [WIDTH-1:0] exps[5] = '{16'hFFFF, 16'h5555, 16'h0034, 16'h3CC3, 16'hEDCB};
        do_reset();
        rsp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1; req0_op = ops[i]; req0_a = as[i]; req0_b = bs[i];
            #1;
            total_cnt++;
            if (req0_ready !== 1'b1) $display("FAIL single_ready op%0d: got %b, required 1", i, req0_ready);
            else pass_cnt++;
            tick();
            req0_valid = 0;
            #1;
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== exps[i] || busy !== 1'b1)
                $display("FAIL single_rsp op%0d: valid=%b id=%b data=%h busy=%b, required 1/0/%h/1",
                         i, rsp_valid, rsp_id, rsp_data, busy, exps[i]);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (rsp_valid !== 1'b0) $display("FAIL single_done op%0d: rsp_valid=%b, required 0", i, rsp_valid);
            else pass_cnt++;
        end
        rsp_ready = 0;
    endtask

    task automatic test_contention();
        int n;
        logic exp_id;
        do_reset();
        rsp_ready  = 1;
        req0_valid = 1; req0_op = 2'd0; req0_a = 16'h0F0F; req0_b = 16'h0000;
        req1_valid = 1; req1_op = 2'd1; req1_a = 16'hFFFF; req1_b = 16'h1234;
        exp_id = 0;
        n = 0;
        for (int c = 0; c < 20 && n < 6; c++) begin
            #1;
            total_cnt++;
            if (req0_ready && req1_ready) $display("FAIL contention_both_ready cyc=%0d: both readys high, required at most one", c);
            else pass_cnt++;
            if (!rsp_valid) begin
                total_cnt++;
                if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01))
                    $display("FAIL contention_grant op%0d: rdy1/rdy0=%b%b, required grant to %0d",
                             n, req1_ready, req0_ready, exp_id);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (rsp_id !== exp_id || rsp_data !== (exp_id ? 16'h1234 : 16'hF0F0))
                    $display("FAIL contention_rsp op%0d: id=%b data=%h, required %0d/%h",
                             n, rsp_id, rsp_data, exp_id, exp_id ? 16'h1234 : 16'hF0F0);
                else pass_cnt++;
                exp_id = ~exp_id;
                n++;
            end
            tick();
        end
        total_cnt++;
        if (n != 6) $display("FAIL contention_count: got %0d responses, required 6", n);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1; req0_op = 2'd0; req0_a = 16'h0001;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_op = 2'd3; req1_a = 16'h00FF; req1_b = 16'h0F0F;
        rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rsp_ready = 1;
            #1;
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'hFFFE || rsp_id !== 1'b0 || busy !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0)
                $display("FAIL backpressure_hold cyc=%0d: valid=%b data=%h id=%b busy=%b rdy0=%b rdy1=%b, required 1/fffe/0/1/0/0",
                         i, rsp_valid, rsp_data, rsp_id, busy, req0_ready, req1_ready);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if (req1_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL backpressure_next_grant: rdy1=%b rsp_valid=%b, required 1/0", req1_ready, rsp_valid);
        else pass_cnt++;
        tick();
        req1_valid = 0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'h0FF0)
            $display("FAIL backpressure_req1_rsp: valid=%b id=%b data=%h, required 1/1/0ff0", rsp_valid, rsp_id, rsp_data);
        else pass_cnt++;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req0_valid = 1; req0_op = 2'd2; req0_a = 16'h00F0; req0_b = 16'h0F00;
        tick();
        req0_valid = 0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0FF0)
            $display("FAIL midreset_pre: valid=%b data=%h, required 1/0ff0", rsp_valid, rsp_data);
        else pass_cnt++;
        reset = 1;
        tick();
        reset = 0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || busy !== 1'b0)
            $display("FAIL midreset_clear: valid=%b data=%h busy=%b, required 0/0000/0", rsp_valid, rsp_data, busy);
        else pass_cnt++;
        req0_valid = 1; req0_op = 2'd0; req0_a = 16'h1111;
        req1_valid = 1; req1_op = 2'd0; req1_a = 16'h2222;
        #1;
        total_cnt++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL midreset_first_grant: rdy0=%b rdy1=%b, required 1/0", req0_ready, req1_ready);
        else pass_cnt++;
        tick();
        idle_inputs();
        #1;
        total_cnt++;
        if (rsp_id !== 1'b0 || rsp_data !== 16'hEEEE)
            $display("FAIL midreset_rsp: id=%b data=%h, required 0/eeee", rsp_id, rsp_data);
        else pass_cnt++;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    task automatic test_late_operand();
        do_reset();
        req1_valid = 1; req1_op = 2'd3; req1_a = 16'h1111; req1_b = 16'h0101;
        tick();
        req1_a = 16'hFFFF; req1_b = 16'h0000; req1_op = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (rsp_data !== 16'h1010 || rsp_id !== 1'b1)
                $display("FAIL late_operand cyc=%0d: data=%h id=%b, required 1010/1", i, rsp_data, rsp_id);
            else pass_cnt++;
            tick();
        end
        idle_inputs();
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    // Randomized traffic against a transaction-level model: the model only tracks
    // whether a result is outstanding, what it is, and who was served last.
    task automatic test_random();
        logic [WIDTH-1:0] exp_q[$];
        logic             exp_id_q[$];
        logic             last_served;
        int               winner;
        int               accepted, responded;
        do_reset();
        last_served = 1;
        accepted = 0;
        responded = 0;
        for (int c = 0; c < 400; c++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_op = 2'($urandom_range(0, 3)); req0_a = 16'($urandom); req0_b = 16'($urandom);
            req1_op = 2'($urandom_range(0, 3)); req1_a = 16'($urandom); req1_b = 16'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            winner = -1;
            if (exp_q.size() == 0) begin
                if (req0_valid && req1_valid) winner = last_served ? 0 : 1;
                else if (req0_valid) winner = 0;
                else if (req1_valid) winner = 1;
            end
            total_cnt++;
            if (req0_ready !== (winner == 0) || req1_ready !== (winner == 1) ||
                rsp_valid !== (exp_q.size() != 0))
                $display("FAIL random_ctrl cyc=%0d: rdy0=%b rdy1=%b valid=%b, required %b/%b/%b",
                         c, req0_ready, req1_ready, rsp_valid, winner == 0, winner == 1, exp_q.size() != 0);
            else pass_cnt++;
            if (exp_q.size() != 0) begin
                total_cnt++;
                if (rsp_data !== exp_q[0] || rsp_id !== exp_id_q[0])
                    $display("FAIL random_rsp cyc=%0d: data=%h id=%b, required %h/%b",
                             c, rsp_data, rsp_id, exp_q[0], exp_id_q[0]);
                else pass_cnt++;
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_id_q.pop_front());
                    responded++;
                end
            end else if (winner == 0) begin
                exp_q.push_back(ref_op(req0_op, req0_a, req0_b));
                exp_id_q.push_back(1'b0);
                last_served = 0;
                accepted++;
            end else if (winner == 1) begin
                exp_q.push_back(ref_op(req1_op, req1_a, req1_b));
                exp_id_q.push_back(1'b1);
                last_served = 1;
                accepted++;
            end
            tick();
        end
        total_cnt++;
        if (accepted < 50) $display("FAIL random_activity: only %0d accepts, required at least 50", accepted);
        else pass_cnt++;
        idle_inputs();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1;
        idle_inputs();
        test_reset();
        test_single_ops();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        test_late_operand();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bitwise_arbiter.md
# bitwise_arbiter

Shares one 16-bit bitwise logic unit (NOT/AND/OR/XOR) between two requesters. Each requester presents an operation with a valid/ready handshake. A round-robin arbiter grants one request at a time. The result is registered and returned on a single response channel tagged with the requester id, which is held until the consumer accepts it. The block sits between the ALU-level gate chips and any sequencer that needs shared bitwise operations without instantiating duplicate gate arrays.

## Interface
- WIDTH, 16, operand/result width (only 16 is verified)
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- req0_valid  in  1  requester 0 has an operation pending
- req0_op  in  2  00 NOT a, 01 a AND b, 10 a OR b, 11 a XOR b
- req0_a  in  WIDTH  operand a
- req0_b  in  WIDTH  operand b (ignored for NOT)
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0
- rsp_valid  out  1  result available
- rsp_id  out  1  requester that issued the result
- rsp_data  out  WIDTH  result
- rsp_ready  in  1  consumer accepts result when rsp_valid&rsp_ready
- busy  out  1  high whenever state is RESP

## Operation
- States: IDLE, RESP. Reset -> IDLE, last_grant=1 (requester 0 wins first tie).
- IDLE: the winner is the only valid requester if exactly one is valid. If both are valid, the winner is the requester other than last_grant. If neither is valid, no grant.
- req0_ready/req1_ready are combinational: high only for the winner, only in IDLE. Both are never high together.
- Transfer on reqN_valid & reqN_ready at a rising edge. That edge does the following:
  - latches rsp_data = op(a,b) and rsp_id = N
  - sets last_grant = N
  - moves to RESP
- RESP: rsp_valid=1. rsp_data and rsp_id are held stable, and both reqN_ready are 0. On rsp_valid & rsp_ready the block returns to IDLE. There is no same-edge re-accept.
- Requester inputs may change freely while not granted. Only values present at the accepting edge are used.
- Ops are bitwise over all WIDTH bits. No carries, no flags.
- Reset has priority over every other event, including mid-RESP. A pending result is discarded, and no response is produced for it.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, req0_ready=0 unless req0_valid in IDLE (combinational), req1_ready likewise.
- Latency: accept at edge N -> rsp_valid=1 after edge N. The earliest rsp handshake is at edge N+1. The earliest next accept is at edge N+2.
- Peak throughput: one operation per 2 cycles.
- With rsp_ready held low for k cycles, rsp_valid/rsp_data/rsp_id stay constant for k+1 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1 starting with 0 after reset. No requester waits more than one other grant.
- reqN_valid dropping in the same cycle as ready is legal. No transfer occurs, and last_grant is unchanged.

## Test plan
- Reset and idle: after reset with no requests, all outputs read 0 and there are no grants. Check this for 5 cycles.
- Single-op correctness via requester 0, with rsp_ready=1:
  - NOT 0x0000 -> 0xFFFF
  - NOT 0xAAAA -> 0x5555
  - AND 0x1234,0x00FF -> 0x0034
  - OR 0x3C00,0x00C3 -> 0x3CC3
  - XOR 0xFFFF,0x1234 -> 0xEDCB
  - rsp_id=0 each time, and rsp_valid one cycle after accept.
- Contention: both requesters continuously valid for 6 operations. Req0 op NOT 0x0F0F, req1 op AND 0xFFFF,0x1234. Responses alternate id 0,1,0,1,0,1 with data 0xF0F0, 0x1234. A ready is never asserted on both requesters at once.
- Backpressure: accept NOT 0x0001, then hold rsp_ready=0 for 3 cycles.
  - rsp_data=0xFFFE and busy=1 stay stable for 4 cycles.
  - Both readys stay 0 while req1_valid is high.
  - req1 is granted the cycle after the rsp handshake.
- Reset mid-operation: accept OR 0x00F0,0x0F00, then assert reset during RESP.
  - The next cycle shows rsp_valid=0, rsp_data=0, busy=0.
  - With both valid, the first grant after reset goes to requester 0.
- Late operand change: change req1_a after acceptance while in RESP. rsp_data reflects the accepted value only.
